// File: rtl/div_pkg.sv
// Shared definitions for the divider-sharing controller: FSM state
// encoding, the done-blanking length and a width helper.
package div_pkg;

    // Controller FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        BLANK = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // The divider's done output lags its start by two cycles, so a done seen
    // within this many cycles after the start pulse belongs to the previous op.
    localparam int BLANK_CYCLES = 2;

    // Bits needed to index 'value' items; never returns less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// 'pointer', wrapping at NREQ. The pointer register lives in the caller.
module div_rr_arb
    import div_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  pointer,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    // Scan requesters starting at the pointer and keep the first hit
    always_comb begin
        int  j;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(pointer) + k;
            if (j >= NREQ) j = j - NREQ;
            if (enable && !found && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider between NREQ requesters. One division is
// outstanding at a time; requesters are served round-robin. The divider's
// stale done is blanked for BLANK_CYCLES after each start pulse, and the
// result is returned tagged with the requester index.
// Optional feature macro: DIV_ZERO_CHECK_EN -- a zero divisor is answered
// locally (rsp_err=1, quotient all ones, remainder = dividend) without
// starting the divider.
//
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high; valid never depends on ready. req_ready is a one-hot grant raised only
// in IDLE. rsp_valid, once raised, holds with stable rsp_* until rsp_ready.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter  int n    = 4,
    parameter  int NREQ = 2,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*n-1:0] req_divisor,
    input  logic [NREQ*n-1:0] req_dividend,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [n-1:0]      rsp_quotient,
    output logic [n-1:0]      rsp_remainder,
    output logic              rsp_err,
    output logic              div_start,
    output logic [n-1:0]      div_divisor,
    output logic [n-1:0]      div_dividend,
    input  logic              div_done,
    input  logic [n-1:0]      div_quotient,
    input  logic [n-1:0]      div_remainder
);

    localparam int BCW = clog2(BLANK_CYCLES);

    state_t          state;
    state_t          state_nxt;
    logic [BCW-1:0]  blank_cnt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic            zero_grant;
    logic [n-1:0]    sel_divisor;
    logic [n-1:0]    sel_dividend;
    logic [n-1:0]    op_divisor;
    logic [n-1:0]    op_dividend;

    div_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (req_valid),
        .pointer   (rr_ptr),
        .enable    (state == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_any = |grant;
    assign req_ready = grant;

    // Route the granted requester's operands to the latch inputs
    always_comb begin
        sel_divisor  = '0;
        sel_dividend = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                sel_divisor  = req_divisor[k*n +: n];
                sel_dividend = req_dividend[k*n +: n];
            end
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    assign zero_grant = grant_any && (sel_divisor == '0);
`else
    assign zero_grant = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_any) state_nxt = zero_grant ? RESP : ISSUE;
            end
            ISSUE: state_nxt = BLANK;
            BLANK: begin
                if (blank_cnt == BCW'(BLANK_CYCLES - 1)) state_nxt = WAIT;
            end
            WAIT: begin
                if (div_done) state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Start pulse and response valid are pure state decodes
    assign div_start = (state == ISSUE);
    assign rsp_valid = (state == RESP);

    // Count the cycles spent blanking the divider's done
    always_ff @(posedge clk) begin
        if (reset) begin
            blank_cnt <= '0;
        end else if (state == ISSUE) begin
            blank_cnt <= '0;
        end else if (state == BLANK) begin
            blank_cnt <= blank_cnt + 1'b1;
        end
    end

    // Latch operands, requester id and advance the round-robin pointer on grant
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            op_divisor  <= '0;
            op_dividend <= '0;
            rsp_id      <= '0;
        end else if (state == IDLE && grant_any) begin
            rr_ptr      <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            op_divisor  <= sel_divisor;
            op_dividend <= sel_dividend;
            rsp_id      <= grant_idx;
        end
    end

    assign div_divisor  = op_divisor;
    assign div_dividend = op_dividend;

    // Capture the divider result, or the local divide-by-zero answer
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
        end else if (state == IDLE && zero_grant) begin
            rsp_quotient  <= '1;
            rsp_remainder <= sel_dividend;
        end else if (state == WAIT && div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic err_q;

    // Error flag follows the kind of the most recent grant
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == IDLE && grant_any) begin
            err_q <= zero_grant;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
